instr_fetch_unit: RTL and testbench

//   Fetch stage of the RV32I core. Owns the PC and issues word reads to instruction memory.

---
 rtl/rv_core_pkg.sv | 37 +++
 rtl/fetch_fifo.sv | 82 ++++++++
 rtl/instr_fetch_unit.sv | 156 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_core_pkg.sv
// Shared RV32I core definitions: widths, constants, opcodes and the fetch entry type.
package rv_core_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Major opcodes shared with decode and ImmGen.
  localparam logic [6:0] OP_LOAD   = 7'b000_0011;
  localparam logic [6:0] OP_IMM    = 7'b001_0011;
  localparam logic [6:0] OP_STORE  = 7'b010_0011;
  localparam logic [6:0] OP_BRANCH = 7'b110_0011;
  localparam logic [6:0] OP_JALR   = 7'b110_0111;
  localparam logic [6:0] OP_JAL    = 7'b110_1111;
  localparam logic [6:0] OP_LUI    = 7'b011_0111;
  localparam logic [6:0] OP_AUIPC  = 7'b001_0111;

  // One buffered fetch result as handed to decode.
  typedef struct packed {
    logic            fault;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

  // Sequential next PC; wraps modulo 2^32.
  function automatic logic [XLEN-1:0] pc_incr(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic pc_misaligned(input logic [XLEN-1:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Registered instruction buffer: DEPTH entries of {fault, pc, instr}, flush has priority.
module fetch_fifo
  import rv_core_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  fetch_entry_t               wdata_i,
  input  logic                       pop_i,
  output fetch_entry_t               rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  fetch_entry_t    mem_q [DEPTH];
  fetch_entry_t    mem_d [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A push into a full buffer is legal only when a pop frees the slot in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer/count and storage next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata_i;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + (do_push ? CntW'(1) : '0) - (do_pop ? CntW'(1) : '0);
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; validity comes from count_q.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: owns the PC, issues credit-limited word reads, buffers responses
// and discards stale ones after a redirect.
module instr_fetch_unit
  import rv_core_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_fault
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     resp_pc_q, resp_pc_d;
  logic [CntW-1:0] inflight_q, inflight_d;
  logic [CntW-1:0] drop_q, drop_d;
  logic            halted_q, halted_d;
  logic            fault_pend_q, fault_pend_d;
  logic            init_done_q, init_done_d;

  logic            req_hs, rsp_keep, fault_push, redir_misaligned;
  logic [CntW-1:0] hs_inc, rsp_dec;
  logic [CntW:0]   occupancy;

  logic            fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [CntW-1:0] fifo_count;
  fetch_entry_t    fifo_wdata, fifo_rdata;

  // Credits cover both in-flight and buffered fetches, so responses can never overflow.
  assign occupancy      = {1'b0, inflight_q} + {1'b0, fifo_count};
  assign imem_req_valid = rst_n && init_done_q && !halted_q && !fault_pend_q && !redirect_valid &&
                          (occupancy < (CntW + 1)'(FIFO_DEPTH));
  assign imem_req_addr  = {fetch_pc_q[31:2], 2'b00};
  assign req_hs         = imem_req_valid && imem_req_ready;

  assign hs_inc           = req_hs ? CntW'(1) : '0;
  assign rsp_dec          = imem_rsp_valid ? CntW'(1) : '0;
  assign redir_misaligned = pc_misaligned(redirect_pc);

  // Responses are kept only when nothing stale is still outstanding.
  assign rsp_keep   = imem_rsp_valid && !redirect_valid && (drop_q == '0);
  // Fault marker waits until every stale response has drained.
  assign fault_push = fault_pend_q && !redirect_valid && (drop_q == '0);

  assign fifo_push = rsp_keep || fault_push;
  assign fifo_pop  = if_valid && if_ready && !redirect_valid;

  // Select what enters the buffer this cycle.
  always_comb begin
    fifo_wdata       = '0;
    fifo_wdata.pc    = resp_pc_q;
    fifo_wdata.instr = imem_rsp_data;
    fifo_wdata.fault = 1'b0;
    if (fault_push) begin
      fifo_wdata.instr = NOP_INSTR;
      fifo_wdata.fault = 1'b1;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (redirect_valid),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign if_valid = rst_n && !fifo_empty;
  assign if_pc    = fifo_rdata.pc;
  assign if_instr = fifo_rdata.instr;
  assign if_fault = if_valid && fifo_rdata.fault;

  // PC, credit and drop bookkeeping; a redirect overrides everything else.
  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    resp_pc_d    = resp_pc_q;
    inflight_d   = inflight_q;
    drop_d       = drop_q;
    halted_d     = halted_q;
    fault_pend_d = fault_pend_q;
    init_done_d  = 1'b1;
    if (redirect_valid) begin
      fetch_pc_d   = redirect_pc;
      resp_pc_d    = redirect_pc;
      inflight_d   = inflight_q - rsp_dec;
      drop_d       = inflight_q - rsp_dec;
      halted_d     = redir_misaligned;
      fault_pend_d = redir_misaligned;
    end else begin
      if (req_hs) begin
        fetch_pc_d = pc_incr(fetch_pc_q);
      end
      inflight_d = inflight_q + hs_inc - rsp_dec;
      if (imem_rsp_valid && (drop_q != '0)) begin
        drop_d = drop_q - CntW'(1);
      end
      if (rsp_keep) begin
        resp_pc_d = pc_incr(resp_pc_q);
      end
      if (fault_push) begin
        fault_pend_d = 1'b0;
      end
    end
  end

  // Fetch control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q   <= RESET_PC;
      resp_pc_q    <= RESET_PC;
      inflight_q   <= '0;
      drop_q       <= '0;
      halted_q     <= 1'b0;
      fault_pend_q <= 1'b0;
      init_done_q  <= 1'b0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      resp_pc_q    <= resp_pc_d;
      inflight_q   <= inflight_d;
      drop_q       <= drop_d;
      halted_q     <= halted_d;
      fault_pend_q <= fault_pend_d;
      init_done_q  <= init_done_d;
    end
  end

  // Memory must never answer more than was asked, and drop never exceeds what is outstanding.
  a_rsp_has_inflight: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (inflight_q != '0));
  a_drop_le_inflight: assert property (@(posedge clk) disable iff (!rst_n)
    drop_q <= inflight_q);
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_keep && fifo_full) |-> fifo_pop);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit with a fixed-latency in-order memory model.
module tb_instr_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_fault;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  int          t0    = 0;
  int          lat   = 1;
  int          hs_cnt = 0;
  logic [31:0] exp_addr;
  logic        halted_m;
  exp_t        sb[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  instr_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_fault       (if_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock: observe at negedge+1, let the edge happen, then drive the memory response.
  task automatic tick();
    exp_t e;
    #1;
    if (rst_n) begin
      if (halted_m && !redirect_valid) check("halted_no_req", {31'b0, imem_req_valid}, 32'd0);
      if (imem_req_valid && imem_req_ready) begin
        check("req_addr", imem_req_addr, exp_addr);
        pend_addr.push_back(imem_req_addr);
        pend_due.push_back(cyc + lat);
        hs_cnt++;
        if (!halted_m) begin
          sb.push_back('{pc: imem_req_addr, instr: mem_word(imem_req_addr), fault: 1'b0});
          exp_addr = exp_addr + 32'd4;
        end
      end
      if (redirect_valid) begin
        sb.delete();
        exp_addr = redirect_pc;
        halted_m = (redirect_pc[1:0] != 2'b00);
        if (halted_m) sb.push_back('{pc: redirect_pc, instr: 32'h0000_0013, fault: 1'b1});
      end else if (if_valid && if_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out_pc", if_pc, 32'hDEAD_BEEF);
        end else begin
          e = sb.pop_front();
          check("out_pc", if_pc, e.pc);
          check("out_instr", if_instr, e.instr);
          check("out_fault", {31'b0, if_fault}, {31'b0, e.fault});
        end
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    if (!rst_n) begin
      pend_addr.delete();
      pend_due.delete();
    end else if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
  endtask

  // Called at a negedge; leaves the DUT in its first cycle after reset release.
  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    #1;
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("rst_if_valid", {31'b0, if_valid}, 32'd0);
    check("rst_if_fault", {31'b0, if_fault}, 32'd0);
    tick();
    tick();
    sb.delete();
    pend_addr.delete();
    pend_due.delete();
    exp_addr = 32'h0;
    halted_m = 1'b0;
    hs_cnt   = 0;
    rst_n    = 1'b1;
    #1;
    check("post_rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("post_rst_if_valid", {31'b0, if_valid}, 32'd0);
    t0 = cyc;
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Stop issuing, then let every expected entry come out.
  task automatic drain(input string tag);
    imem_req_ready = 1'b0;
    if_ready       = 1'b1;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (sb.size() == 0 && pend_addr.size() == 0 && !if_valid) break;
      tick();
    end
    check({tag, "_drained"}, sb.size(), 32'd0);
  endtask

  initial begin
    bit found;
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    if_ready       = 1'b1;
    halted_m       = 1'b0;
    exp_addr       = 32'h0;
    @(negedge clk);

    // 1: streaming after reset, first output three edges after release.
    lat = 1;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (if_valid && !found) begin
        found = 1'b1;
        check("t1_first_cycle", cyc - t0, 32'd3);
        check("t1_first_pc", if_pc, 32'h0);
      end
      tick();
    end
    check("t1_first_seen", {31'b0, found}, 32'd1);
    drain("t1");

    // 2: decode stalled, credit limits requests to FIFO_DEPTH.
    imem_req_ready = 1'b1;
    if_ready       = 1'b0;
    do_reset();
    run(10);
    #1;
    check("t2_req_count", hs_cnt, 32'd2);
    check("t2_req_idle", {31'b0, imem_req_valid}, 32'd0);
    check("t2_hold_valid", {31'b0, if_valid}, 32'd1);
    check("t2_hold_pc", if_pc, 32'h0);
    if_ready = 1'b1;
    run(8);
    drain("t2");

    // 3a: redirect with two fetches in flight.
    imem_req_ready = 1'b1;
    if_ready       = 1'b1;
    lat            = 4;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (pend_addr.size() >= 2) break;
      tick();
    end
    #1;
    check("t3_two_inflight", pend_addr.size(), 32'd2);
    check("t3_credit_out", {31'b0, imem_req_valid}, 32'd0);
    redirect(32'h0000_0100);
    lat = 1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      #1;
      if (if_valid) begin
        found = 1'b1;
        check("t3_first_pc", if_pc, 32'h100);
      end else tick();
    end
    check("t3_first_seen", {31'b0, found}, 32'd1);
    run(6);
    drain("t3a");

    // 3b: redirect while the FIFO holds valid entries.
    imem_req_ready = 1'b1;
    if_ready       = 1'b0;
    do_reset();
    run(6);
    redirect(32'h0000_0100);
    if_ready = 1'b1;
    run(6);
    drain("t3b");

    // 4: redirect coinciding with a response and a pop.
    imem_req_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      #1;
      if (imem_rsp_valid && if_valid) break;
      tick();
    end
    check("t4_collision", {31'b0, imem_rsp_valid && if_valid}, 32'd1);
    redirect(32'h0000_0300);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      #1;
      if (if_valid) begin
        found = 1'b1;
        check("t4_first_pc", if_pc, 32'h300);
      end else tick();
    end
    check("t4_first_seen", {31'b0, found}, 32'd1);
    run(4);
    drain("t4");

    // 5: misaligned redirect produces one fault entry then halts.
    imem_req_ready = 1'b1;
    lat            = 2;
    do_reset();
    run(5);
    redirect(32'h0000_0102);
    run(10);
    #1;
    check("t5_fault_delivered", sb.size(), 32'd0);
    check("t5_idle", {31'b0, imem_req_valid}, 32'd0);
    redirect(32'h0000_0200);
    #1;
    check("t5_resume_addr", imem_req_addr, 32'h200);
    run(6);
    drain("t5");

    // 6: PC wrap, then reset mid-stream.
    imem_req_ready = 1'b1;
    lat            = 1;
    do_reset();
    run(3);
    redirect(32'hFFFF_FFF8);
    run(8);
    check("t6_wrapped", {31'b0, exp_addr < 32'h100}, 32'd1);
    do_reset();
    run(8);
    drain("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
